// File: rtl/exe_stage_pipe_pkg.sv
// Shared encodings for the execute stage: instruction types, ALU/condition
// opcodes and the stage FSM state type.
package exe_pkg;

  localparam logic [1:0] ITYPE_R   = 2'b00;
  localparam logic [1:0] ITYPE_BR  = 2'b01;
  localparam logic [1:0] ITYPE_I   = 2'b10;
  localparam logic [1:0] ITYPE_RSV = 2'b11;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;

  localparam logic [3:0] COND_EQ  = 4'h0;
  localparam logic [3:0] COND_NE  = 4'h1;
  localparam logic [3:0] COND_LT  = 4'h2;
  localparam logic [3:0] COND_GE  = 4'h3;
  localparam logic [3:0] COND_LTU = 4'h4;
  localparam logic [3:0] COND_GEU = 4'h5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } exe_state_e;

  // The opcode lives in a different instruction field for each type.
  function automatic logic [3:0] sel_opcode(input logic [1:0] itype,
                                            input logic [3:0] imm_lo,
                                            input logic [3:0] rd_lo,
                                            input logic [3:0] rs2_lo);
    logic [3:0] op;
    case (itype)
      ITYPE_R:  op = imm_lo;
      ITYPE_BR: op = rd_lo;
      ITYPE_I:  op = rs2_lo;
      default:  op = 4'h0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/exe_stage_pipe_if.sv
// Decoded-instruction input and result output of the execute stage,
// each with its own valid/ready handshake.
interface exe_stage_pipe_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;
  logic [XLEN-1:0]    imm;
  logic [1:0]         instr_type;
  logic               is_computational;
  logic               is_load_store;
  logic [RADDR_W-1:0] rs2;
  logic [RADDR_W-1:0] rd;
  logic [XLEN-1:0]    pc_in;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    exe_out;
  logic               z_flag;
  logic [XLEN-1:0]    pc_out;
  logic               is_load_store_out;

  modport slave (
    input  in_valid, rs1_val, rs2_val, imm, instr_type, is_computational,
           is_load_store, rs2, rd, pc_in, out_ready,
    output in_ready, out_valid, exe_out, z_flag, pc_out, is_load_store_out
  );

  modport master (
    output in_valid, rs1_val, rs2_val, imm, instr_type, is_computational,
           is_load_store, rs2, rd, pc_in, out_ready,
    input  in_ready, out_valid, exe_out, z_flag, pc_out, is_load_store_out
  );
endinterface

// File: rtl/exe_stage_pipe_alu.sv
// Combinational compute and condition unit. MUL is iterative and lives in the
// stage FSM, so opcode 8 returns zero here.
module exe_alu
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] comp_res,
  output logic            cond
);
  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;

  assign shamt = op2[SH_W-1:0];

  always_comb begin
    comp_res = '0;
    case (op)
      OP_ADD: comp_res = op1 + op2;
      OP_SUB: comp_res = op1 - op2;
      OP_AND: comp_res = op1 & op2;
      OP_OR:  comp_res = op1 | op2;
      OP_XOR: comp_res = op1 ^ op2;
      OP_SLL: comp_res = op1 << shamt;
      OP_SRL: comp_res = op1 >> shamt;
      OP_SRA: comp_res = $signed(op1) >>> shamt;
      default: comp_res = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (op)
      COND_EQ:  cond = (op1 == op2);
      COND_NE:  cond = (op1 != op2);
      COND_LT:  cond = ($signed(op1) <  $signed(op2));
      COND_GE:  cond = ($signed(op1) >= $signed(op2));
      COND_LTU: cond = (op1 <  op2);
      COND_GEU: cond = (op1 >= op2);
      default:  cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/exe_stage_pipe.sv
// Registered execute stage: operand/opcode select, ALU or iterative shift-add
// multiply, and a single output register with back-pressure and flush.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | accepting instructions; non-MUL results load the output reg
//   ST_MUL  | one shift-add step per cycle; last step loads the output reg
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 4,
  parameter bit MUL_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  exe_stage_pipe_if.slave      bus
);
  localparam int CNT_W = $clog2(XLEN);

  exe_state_e state_q, state_d;

  logic [XLEN-1:0]  op1, op2, alu_res, result, mul_sum;
  logic [3:0]       opcode;
  logic             cond, out_free, accept, is_mul, mul_last;
  logic             start_mul, load_alu, load_mul;

  logic [XLEN-1:0]  mcand_q, mplier_q, acc_q, mul_pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_ls_q;

  logic             out_valid_q, z_q, ls_q;
  logic [XLEN-1:0]  exe_out_q, pc_out_q;

  assign op1    = bus.rs1_val;
  assign op2    = (bus.instr_type[1] | bus.is_load_store) ? bus.imm : bus.rs2_val;
  assign opcode = sel_opcode(bus.instr_type, bus.imm[3:0], bus.rd[3:0], bus.rs2[3:0]);

  exe_alu #(.XLEN(XLEN)) u_alu (
    .op1      (op1),
    .op2      (op2),
    .op       (opcode),
    .comp_res (alu_res),
    .cond     (cond)
  );

  assign result   = bus.is_computational ? alu_res : (bus.pc_in + bus.imm);
  assign out_free = !out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & bus.in_ready & !flush;
  // Non-computational op 8 is a branch-style pc+imm, not a multiply.
  assign is_mul   = MUL_EN && (opcode == OP_MUL) && bus.is_computational;
  assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == CNT_W'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_mul = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            start_mul = 1'b1;
            state_d   = ST_MUL;
          end else begin
            load_alu  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        // Final step waits for a free output slot so a held result is never overwritten.
        if (mul_last && out_free) begin
          load_mul = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d   = ST_IDLE;
      start_mul = 1'b0;
      load_alu  = 1'b0;
      load_mul  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mul_pc_q <= '0;
      mul_ls_q <= 1'b0;
    end else if (start_mul) begin
      mcand_q  <= op1;
      mplier_q <= op2;
      acc_q    <= '0;
      cnt_q    <= '0;
      mul_pc_q <= bus.pc_in;
      mul_ls_q <= bus.is_load_store;
    end else if (state_q == ST_MUL && !mul_last) begin
      acc_q    <= mul_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      exe_out_q   <= '0;
      z_q         <= 1'b0;
      pc_out_q    <= '0;
      ls_q        <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load_alu) begin
      out_valid_q <= 1'b1;
      exe_out_q   <= result;
      z_q         <= cond;
      pc_out_q    <= bus.pc_in;
      ls_q        <= bus.is_load_store;
    end else if (load_mul) begin
      out_valid_q <= 1'b1;
      exe_out_q   <= mul_sum;
      z_q         <= 1'b0;
      pc_out_q    <= mul_pc_q;
      ls_q        <= mul_ls_q;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready          = (state_q == ST_IDLE) & out_free;
  assign bus.out_valid         = out_valid_q;
  assign bus.exe_out           = exe_out_q;
  assign bus.z_flag            = z_q;
  assign bus.pc_out            = pc_out_q;
  assign bus.is_load_store_out = ls_q;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Self-checking bench for exe_stage_pipe: scenario tasks plus a scoreboard
// monitor that pops expected results as the stage delivers them.
module tb_exe_stage_pipe;
  localparam int XLEN = 32;
  localparam int RW   = 4;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic [31:0] pc;
    logic        ls;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  exe_stage_pipe_if #(.XLEN(XLEN), .RADDR_W(RW)) bus();

  exe_stage_pipe #(.XLEN(XLEN), .RADDR_W(RW), .MUL_EN(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  bit   rand_bp = 1'b0;
  bit   held = 1'b0;
  exp_t held_v;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] rs2v,
                                 input logic [31:0] im, input logic [1:0] t,
                                 input logic comp, input logic ls,
                                 input logic [3:0] rs2f, input logic [3:0] rdf,
                                 input logic [31:0] pc);
    exp_t e;
    logic [31:0] b, r;
    logic [3:0]  op;
    logic        c;
    b = (t[1] || ls) ? im : rs2v;
    case (t)
      2'd0: op = im[3:0];
      2'd1: op = rdf;
      2'd2: op = rs2f;
      default: op = 4'd0;
    endcase
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $signed(a) >>> b[4:0];
      4'd8: r = a * b;
      default: r = 32'd0;
    endcase
    case (op)
      4'd0: c = (a == b);
      4'd1: c = (a != b);
      4'd2: c = ($signed(a) < $signed(b));
      4'd3: c = ($signed(a) >= $signed(b));
      4'd4: c = (a < b);
      4'd5: c = (a >= b);
      default: c = 1'b0;
    endcase
    e.res = comp ? r : (pc + im);
    e.z   = c;
    e.pc  = pc;
    e.ls  = ls;
    return e;
  endfunction

  // Scoreboard monitor plus hold-stability check under back-pressure.
  always @(negedge clk) begin
    exp_t cur, e;
    cur = {bus.exe_out, bus.z_flag, bus.pc_out, bus.is_load_store_out};
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        n_cmp++;
        if (!bus.out_valid || cur !== held_v) begin
          n_err++;
          $display("FAIL hold_stable: got valid=%0b %h, required valid=1 %h", bus.out_valid, cur, held_v);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        n_out++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got exe_out=%h, required no output", bus.exe_out);
        end else begin
          e = sb.pop_front();
          if (cur !== e) begin
            n_err++;
            $display("FAIL scoreboard: got res=%h z=%0b pc=%h ls=%0b, required res=%h z=%0b pc=%h ls=%0b",
                     cur.res, cur.z, cur.pc, cur.ls, e.res, e.z, e.pc, e.ls);
          end
        end
      end
      held   = bus.out_valid && !bus.out_ready && !flush;
      held_v = cur;
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] rs2v, input logic [31:0] im,
                       input logic [1:0] t, input logic comp, input logic ls,
                       input logic [3:0] rs2f, input logic [3:0] rdf, input logic [31:0] pc);
    bus.rs1_val = a;  bus.rs2_val = rs2v; bus.imm = im; bus.instr_type = t;
    bus.is_computational = comp; bus.is_load_store = ls;
    bus.rs2 = rs2f; bus.rd = rdf; bus.pc_in = pc;
  endtask

  // Present one instruction until accepted; push its expected result if asked.
  task automatic send(input logic [31:0] a, input logic [31:0] rs2v, input logic [31:0] im,
                      input logic [1:0] t, input logic comp, input logic ls,
                      input logic [3:0] rs2f, input logic [3:0] rdf, input logic [31:0] pc,
                      input bit push);
    bit ok;
    ok = 1'b0;
    drive(a, rs2v, im, t, comp, ls, rs2f, rdf, pc);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = bus.in_ready && !flush;
      @(posedge clk);
      #1;
    end
    if (ok && push) sb.push_back(model(a, rs2v, im, t, comp, ls, rs2f, rdf, pc));
    bus.in_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL send_timeout: got in_ready never high, required acceptance");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
    n_cmp++; if (bus.exe_out !== 32'd0) begin n_err++; $display("FAIL rst_exe_out: got %h required 0", bus.exe_out); end
    n_cmp++; if (bus.z_flag !== 1'b0) begin n_err++; $display("FAIL rst_z_flag: got %b required 0", bus.z_flag); end
    n_cmp++; if (bus.pc_out !== 32'd0) begin n_err++; $display("FAIL rst_pc_out: got %h required 0", bus.pc_out); end
    n_cmp++; if (bus.is_load_store_out !== 1'b0) begin n_err++; $display("FAIL rst_ls_out: got %b required 0", bus.is_load_store_out); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b required 1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    send(32'd5, 32'd7, 32'd0, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 32'h10, 1'b1);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b required 1", bus.out_valid); end
    n_cmp++; if (bus.exe_out !== 32'd12) begin n_err++; $display("FAIL add_result: got %h required 0000000c", bus.exe_out); end
    n_cmp++; if (bus.z_flag !== 1'b0) begin n_err++; $display("FAIL add_z: got %b required 0", bus.z_flag); end
    @(posedge clk); #1;
  endtask

  task automatic test_branch();
    send(32'hFFFF_FFFF, 32'd1, 32'h20, 2'b01, 1'b0, 1'b0, 4'd0, 4'd2, 32'h100, 1'b1);
    @(negedge clk);
    n_cmp++; if (bus.exe_out !== 32'h120) begin n_err++; $display("FAIL branch_target: got %h required 00000120", bus.exe_out); end
    n_cmp++; if (bus.z_flag !== 1'b1) begin n_err++; $display("FAIL branch_z: got %b required 1", bus.z_flag); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int cyc;
    bit low_ok;
    cyc = 0;
    low_ok = 1'b1;
    send(32'h10001, 32'd0, 32'd3, 2'b10, 1'b1, 1'b0, 4'h8, 4'd0, 32'h40, 1'b1);
    do begin
      @(negedge clk);
      cyc++;
      if (!bus.out_valid && bus.in_ready) low_ok = 1'b0;
    end while (!bus.out_valid && cyc < 100);
    n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL mul_latency: got %0d edges required 33", cyc); end
    n_cmp++; if (!low_ok) begin n_err++; $display("FAIL mul_in_ready: got in_ready high during MUL required low"); end
    n_cmp++; if (bus.exe_out !== 32'h30003) begin n_err++; $display("FAIL mul_result: got %h required 00030003", bus.exe_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int base;
    bus.out_ready = 1'b0;
    send(32'd20, 32'd3, 32'd1, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 32'h200, 1'b1);
    drive(32'd100, 32'd1, 32'd1, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 32'h204);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b required 0", bus.in_ready); end
      n_cmp++; if (bus.exe_out !== 32'd17) begin n_err++; $display("FAIL bp_first_held: got %h required 00000011", bus.exe_out); end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    base = n_out;
    bus.out_ready = 1'b1;
    send(32'd100, 32'd1, 32'd1, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 32'h204, 1'b1);
    @(posedge clk); #1;
    n_cmp++; if (n_out !== base + 2) begin n_err++; $display("FAIL bp_delivered: got %0d outputs required %0d", n_out - base, 2); end
  endtask

  task automatic test_flush();
    bit stray;
    stray = 1'b0;
    send(32'd7, 32'd0, 32'd9, 2'b10, 1'b1, 1'b0, 4'h8, 4'd0, 32'h300, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b required 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b required 1", bus.in_ready); end
    // An instruction offered during a flush cycle must be dropped.
    @(posedge clk); #1;
    drive(32'd1, 32'd1, 32'd0, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 32'h310);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) stray = 1'b1;
    end
    n_cmp++; if (stray) begin n_err++; $display("FAIL flush_no_output: got out_valid=1 required 0"); end
    @(posedge clk); #1;
    send(32'd3, 32'd4, 32'd0, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 32'h320, 1'b1);
    @(negedge clk);
    n_cmp++; if (bus.exe_out !== 32'd7) begin n_err++; $display("FAIL flush_next_add: got %h required 00000007", bus.exe_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mul();
    send(32'd5, 32'd0, 32'd5, 2'b10, 1'b1, 1'b0, 4'h8, 4'd0, 32'h400, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mul_in_ready: got %b required 1", bus.in_ready); end
    repeat (40) @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mul_valid: got %b required 0", bus.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_store();
    send(32'h1000, 32'hDEAD, 32'd4, 2'b00, 1'b1, 1'b1, 4'd0, 4'd0, 32'h500, 1'b1);
    @(negedge clk);
    n_cmp++; if (bus.exe_out !== 32'h1004) begin n_err++; $display("FAIL ls_addr: got %h required 00001004", bus.exe_out); end
    n_cmp++; if (bus.is_load_store_out !== 1'b1) begin n_err++; $display("FAIL ls_flag: got %b required 1", bus.is_load_store_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int waited;
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send($urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom, 1'b1);
    end
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL random_drain: got %0d pending required 0", sb.size()); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive('0, '0, '0, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, '0);
    test_reset();
    test_add();
    test_branch();
    test_mul();
    test_back_to_back();
    test_flush();
    test_rst_mul();
    test_load_store();
    test_random();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
